multiplier_factorize_search: RTL and testbench

//  Sequential, parametrised successor to the fixed-width combinational factorisation benchmarks.
//  - Takes a target product N and searches exhaustively for factors a (A_W bits) and b (B_W bits) with a*b == N.
//  - Reports SAT plus the first witness pair, or UNSAT when the space is exhausted.
//  - Serves as the on-FPGA golden checker/oracle for CSAT results on multiplier_factorize instances.

---
 rtl/mfs_pkg.sv | 21 ++
 rtl/mfs_shift_add_mul.sv | 44 ++++
 rtl/multiplier_factorize_search.sv | 180 ++++++++++++++++++
 tb/tb_multiplier_factorize_search.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfs_pkg.sv
// Shared types and helpers for the exhaustive factor search (multiplier_factorize_search).
package mfs_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        CHECK,
        DONE
    } mfs_state_e;

    localparam int MIN_NONTRIVIAL = 2;
    localparam int MIN_TRIVIAL    = 0;

    // Value with the low 'width' bits set; saturates at 32 bits.
    function automatic logic [31:0] all_ones(input int width);
        if (width >= 32)
            return '1;
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/mfs_shift_add_mul.sv
// Sequential shift-add multiplier: one multiplier bit per step, exact A_W+B_W-bit product.
// Compiled out when MFS_COMB_MUL_EN is defined (the top then multiplies combinationally).
`ifndef MFS_COMB_MUL_EN
module mfs_shift_add_mul #(
    parameter int A_W = 7,
    parameter int B_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [A_W-1:0]     i_a,
    input  logic [B_W-1:0]     i_b,
    output logic [A_W+B_W-1:0] o_product
);

    localparam int P_W = A_W + B_W;

    logic [P_W-1:0] r_acc;
    logic [P_W-1:0] r_mcand;
    logic [B_W-1:0] r_mplier;

    // NOTE: load wins over step so a new operand pair never mixes with a stale partial sum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_load) begin
            r_acc    <= '0;
            r_mcand  <= P_W'(i_a);
            r_mplier <= i_b;
        end else if (i_step) begin
            if (r_mplier[0])
                r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    assign o_product = r_acc;

endmodule
`endif

// File: rtl/multiplier_factorize_search.sv
// Exhaustive search for a*b == target (b outer, a inner, ascending); reports first witness or UNSAT.
// MFS_COMB_MUL_EN: combinational product, one cycle per candidate instead of B_W+1.
module multiplier_factorize_search
    import mfs_pkg::*;
#(
    parameter int A_W = 7,
    parameter int B_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [A_W+B_W-1:0] target,
    input  logic               nontrivial,
    output logic               busy,
    output logic               done,
    output logic               sat,
    output logic [A_W-1:0]     a_out,
    output logic [B_W-1:0]     b_out
);

    localparam int P_W = A_W + B_W;
    localparam logic [A_W-1:0] A_ONES = A_W'(all_ones(A_W));
    localparam logic [B_W-1:0] B_ONES = B_W'(all_ones(B_W));

    generate
        if (A_W < 2 || B_W < 2) begin : g_bad_width
            $error("multiplier_factorize_search: A_W and B_W must both be >= 2");
        end
    endgenerate

    mfs_state_e     r_state;
    logic [P_W-1:0] r_target;
    logic           r_nontriv;
    logic [A_W-1:0] r_a;
    logic [B_W-1:0] r_b;
    logic           r_busy;
    logic           r_done;
    logic           r_sat;
    logic [A_W-1:0] r_a_out;
    logic [B_W-1:0] r_b_out;

    logic [A_W-1:0] w_min_a_in;
    logic [B_W-1:0] w_min_b_in;
    logic [A_W-1:0] w_a_step;
    logic [B_W-1:0] w_b_step;
    logic           w_a_last;
    logic           w_b_last;
    logic [P_W-1:0] w_product;
    logic           w_match;
    logic           w_mul_last;

    // Range start comes from the live input in IDLE, from the latched flag on wrap.
    assign w_min_a_in = nontrivial ? A_W'(MIN_NONTRIVIAL) : A_W'(MIN_TRIVIAL);
    assign w_min_b_in = nontrivial ? B_W'(MIN_NONTRIVIAL) : B_W'(MIN_TRIVIAL);
    assign w_a_last   = (r_a == A_ONES);
    assign w_b_last   = (r_b == B_ONES);
    assign w_a_step   = w_a_last ? (r_nontriv ? A_W'(MIN_NONTRIVIAL) : A_W'(MIN_TRIVIAL))
                                 : r_a + A_W'(1);
    assign w_b_step   = w_a_last ? r_b + B_W'(1) : r_b;
    assign w_match    = (w_product == r_target);

`ifdef MFS_COMB_MUL_EN
    localparam mfs_state_e RUN_STATE = CHECK;

    assign w_product  = P_W'(r_a) * P_W'(r_b);
    assign w_mul_last = 1'b1;
`else
    localparam mfs_state_e RUN_STATE = MUL;
    localparam int CNT_W = $clog2(B_W);

    logic [CNT_W-1:0] r_cnt;
    logic             w_mul_load;
    logic             w_mul_step;
    logic [A_W-1:0]   w_mul_a;
    logic [B_W-1:0]   w_mul_b;

    // Reloading in every IDLE/CHECK cycle is harmless and keeps the control trivial.
    assign w_mul_load = (r_state == IDLE) || (r_state == CHECK);
    assign w_mul_step = (r_state == MUL);
    assign w_mul_a    = (r_state == IDLE) ? w_min_a_in : w_a_step;
    assign w_mul_b    = (r_state == IDLE) ? w_min_b_in : w_b_step;
    assign w_mul_last = (r_cnt == CNT_W'(B_W - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || r_state != MUL)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CNT_W'(1);
    end

    mfs_shift_add_mul #(
        .A_W (A_W),
        .B_W (B_W)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_mul_load),
        .i_step    (w_mul_step),
        .i_a       (w_mul_a),
        .i_b       (w_mul_b),
        .o_product (w_product)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_target  <= '0;
            r_nontriv <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sat     <= 1'b0;
            r_a_out   <= '0;
            r_b_out   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_target  <= target;
                        r_nontriv <= nontrivial;
                        r_a       <= w_min_a_in;
                        r_b       <= w_min_b_in;
                        r_busy    <= 1'b1;
                        r_sat     <= 1'b0;
                        r_a_out   <= '0;
                        r_b_out   <= '0;
                        r_state   <= RUN_STATE;
                    end
                end
                MUL: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_mul_last) begin
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_match) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_sat   <= 1'b1;
                        r_a_out <= r_a;
                        r_b_out <= r_b;
                        r_state <= DONE;
                    end else if (w_a_last && w_b_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_sat   <= 1'b0;
                        r_a_out <= '0;
                        r_b_out <= '0;
                        r_state <= DONE;
                    end else begin
                        r_a     <= w_a_step;
                        r_b     <= w_b_step;
                        r_state <= RUN_STATE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign sat   = r_sat;
    assign a_out = r_a_out;
    assign b_out = r_b_out;

endmodule

// File: tb/tb_multiplier_factorize_search.sv
// Scoreboard bench for multiplier_factorize_search (default A_W=7, B_W=4); honours MFS_COMB_MUL_EN.
module tb_multiplier_factorize_search;

    localparam int A_W = 7;
    localparam int B_W = 4;
    localparam int P_W = A_W + B_W;
`ifdef MFS_COMB_MUL_EN
    localparam int CPC = 1;
`else
    localparam int CPC = B_W + 1;
`endif
    localparam int BUDGET = 12000;

    typedef struct {
        logic sat;
        int   a;
        int   b;
        int   cycle;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [P_W-1:0] target = '0;
    logic           nontrivial = 1'b0;
    logic           busy;
    logic           done;
    logic           sat;
    logic [A_W-1:0] a_out;
    logic [B_W-1:0] b_out;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    multiplier_factorize_search #(
        .A_W (A_W),
        .B_W (B_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .target     (target),
        .nontrivial (nontrivial),
        .busy       (busy),
        .done       (done),
        .sat        (sat),
        .a_out      (a_out),
        .b_out      (b_out)
    );

    // Reference: b outer, a inner, first match wins; cycle is when done is seen.
    function automatic exp_t model(input int t, input bit nt);
        exp_t e;
        int   mn = nt ? 2 : 0;
        int   k = 0;
        e.sat = 1'b0;
        e.a = 0;
        e.b = 0;
        for (int b = mn; b < (1 << B_W); b++) begin
            for (int a = mn; a < (1 << A_W); a++) begin
                k++;
                if (a * b == t) begin
                    e.sat = 1'b1;
                    e.a = a;
                    e.b = b;
                    e.cycle = k * CPC + 1;
                    return e;
                end
            end
        end
        e.cycle = k * CPC + 1;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives start during cycle 0; returns in cycle 1 (first cycle after acceptance).
    task automatic launch(input int t, input bit nt);
        target = P_W'(t);
        nontrivial = nt;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits for done starting at cycle cyc0, pops the scoreboard and compares.
    task automatic wait_done(input int cyc0, input string name);
        int   cyc = cyc0;
        exp_t e;
        while (done !== 1'b1 && cyc < BUDGET) begin
            tick();
            cyc++;
        end
        n_total++;
        if (done !== 1'b1) begin
            $display("FAIL %s timeout: done not seen by cycle %0d", name, cyc);
            return;
        end
        n_pass++;
        n_total++;
        if (sb.size() == 0) begin
            $display("FAIL %s: unexpected done at cycle %0d, scoreboard empty", name, cyc);
            return;
        end
        n_pass++;
        e = sb.pop_front();
        n_total++;
        if (sat !== e.sat) $display("FAIL %s sat: got %0b expected %0b", name, sat, e.sat);
        else n_pass++;
        n_total++;
        if (a_out !== A_W'(e.a)) $display("FAIL %s a_out: got %0d expected %0d", name, a_out, e.a);
        else n_pass++;
        n_total++;
        if (b_out !== B_W'(e.b)) $display("FAIL %s b_out: got %0d expected %0d", name, b_out, e.b);
        else n_pass++;
        n_total++;
        if (cyc !== e.cycle) $display("FAIL %s done cycle: got %0d expected %0d", name, cyc, e.cycle);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL %s busy at done: got %0b expected 0", name, busy);
        else n_pass++;
        tick();
        n_total++;
        if (done !== 1'b0) $display("FAIL %s done pulse width: got %0b expected 0", name, done);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_total++;
        if ({busy, done, sat, a_out, b_out} !== '0)
            $display("FAIL reset outputs: got %0h expected 0", {busy, done, sat, a_out, b_out});
        else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sat();
        exp_t e;
        e.sat = 1'b1; e.a = 13; e.b = 11; e.cycle = 1146 * CPC + 1;
        sb.push_back(e);
        launch(143, 1'b1);
        n_total++;
        if (busy !== 1'b1) $display("FAIL sat busy after start: got %0b expected 1", busy);
        else n_pass++;
        wait_done(1, "sat143");
    endtask

    task automatic test_hold();
        repeat (5) tick();
        n_total++;
        if ({sat, a_out, b_out} !== {1'b1, A_W'(13), B_W'(11)})
            $display("FAIL hold results: got sat=%0b a=%0d b=%0d expected 1/13/11", sat, a_out, b_out);
        else n_pass++;
    endtask

    task automatic test_unsat();
        exp_t e;
        e.sat = 1'b0; e.a = 0; e.b = 0; e.cycle = 1764 * CPC + 1;
        sb.push_back(e);
        launch(211, 1'b1);
        n_total++;
        if ({sat, a_out, b_out} !== '0)
            $display("FAIL unsat clear on start: got sat=%0b a=%0d b=%0d expected 0", sat, a_out, b_out);
        else n_pass++;
        wait_done(1, "unsat211");
    endtask

    task automatic test_zero();
        sb.push_back(model(0, 1'b0));
        launch(0, 1'b0);
        wait_done(1, "zero_trivial");
        sb.push_back(model(0, 1'b1));
        launch(0, 1'b1);
        wait_done(1, "zero_nontrivial");
    endtask

    task automatic test_start_abort_idle();
        sb.push_back(model(0, 1'b0));
        abort = 1'b1;
        launch(0, 1'b0);
        abort = 1'b0;
        wait_done(1, "start_with_abort");
    endtask

    task automatic test_ignored_start();
        int cyc = 1;
        sb.push_back(model(143, 1'b1));
        launch(143, 1'b1);
        while (cyc < 200) begin
            tick();
            cyc++;
        end
        target = P_W'(211);
        nontrivial = 1'b0;
        start = 1'b1;
        tick();
        cyc++;
        start = 1'b0;
        wait_done(cyc, "ignored_start");
    endtask

    task automatic test_abort();
        int  cyc = 1;
        bit  seen = 1'b0;
        exp_t e;
        launch(143, 1'b1);
        while (cyc < 100) begin
            tick();
            cyc++;
            if (done === 1'b1) seen = 1'b1;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_total++;
        if (busy !== 1'b0) $display("FAIL abort busy at cycle 101: got %0b expected 0", busy);
        else n_pass++;
        repeat (30) begin
            if (done === 1'b1) seen = 1'b1;
            tick();
        end
        n_total++;
        if (seen) $display("FAIL abort done pulse: got 1 expected 0");
        else n_pass++;
        n_total++;
        if ({sat, a_out, b_out} !== '0)
            $display("FAIL abort results: got sat=%0b a=%0d b=%0d expected 0", sat, a_out, b_out);
        else n_pass++;
        e.sat = 1'b1; e.a = 13; e.b = 11; e.cycle = 1146 * CPC + 1;
        sb.push_back(e);
        launch(143, 1'b1);
        wait_done(1, "after_abort");
    endtask

    task automatic test_reset_mid();
        int cyc = 1;
        bit seen = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_total++;
        if ({sat, a_out, b_out} !== '0)
            $display("FAIL idle reset results: got sat=%0b a=%0d b=%0d expected 0", sat, a_out, b_out);
        else n_pass++;
        tick();
        launch(143, 1'b1);
        while (cyc < 50) begin
            tick();
            cyc++;
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_total++;
        if ({busy, done, sat, a_out, b_out} !== '0)
            $display("FAIL mid reset outputs: got %0h expected 0", {busy, done, sat, a_out, b_out});
        else n_pass++;
        repeat (20) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        n_total++;
        if (seen) $display("FAIL mid reset done pulse: got 1 expected 0");
        else n_pass++;
        sb.push_back(model(15, 1'b1));
        launch(15, 1'b1);
        wait_done(1, "post_reset15");
    endtask

    initial begin
        test_reset();
        test_sat();
        test_hold();
        test_unsat();
        test_zero();
        test_start_abort_idle();
        test_ignored_start();
        test_abort();
        test_reset_mid();
        n_total++;
        if (sb.size() != 0) $display("FAIL scoreboard leftover: got %0d entries expected 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
